// File: rtl/alu_pipe.sv
// Pipelined ALU stage with valid/ready handshakes on both sides.
// Single-cycle ops register their result on accept; MUL iterates one partial product per cycle.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       code,
    input  logic             sgn,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Z,
    output logic             CMP_Flag,
    output logic             C_Flag,
    output logic             Z_Flag
);

    localparam logic [5:0] OP_ADD = 6'd0;
    localparam logic [5:0] OP_SUB = 6'd1;
    localparam logic [5:0] OP_MUL = 6'd2;
    localparam logic [5:0] OP_AND = 6'd3;
    localparam logic [5:0] OP_OR  = 6'd4;
    localparam logic [5:0] OP_XOR = 6'd5;
    localparam logic [5:0] OP_NOT = 6'd6;
    localparam logic [5:0] OP_MAX = 6'd7;
    localparam logic [5:0] OP_LT  = 6'd8;
    localparam logic [5:0] OP_EQ  = 6'd9;
    localparam logic [5:0] OP_LE  = 6'd10;
    localparam logic [5:0] OP_SHL = 6'd11;
    localparam logic [5:0] OP_SHR = 6'd12;
    localparam logic [5:0] OP_SRA = 6'd13;
    localparam logic [5:0] OP_MIN = 6'd14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] z_reg, z_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] mcand_reg, mcand_next;
    logic [WIDTH-1:0] mplier_reg, mplier_next;
    logic [SHW-1:0]   cnt_reg, cnt_next;
    logic             cmp_reg, cmp_next;
    logic             c_reg, c_next;
    logic             zf_reg, zf_next;

    logic             accept;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic             x_lt_y;
    logic             y_lt_x;
    logic             x_eq_y;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] x_rev;
    logic [WIDTH-1:0] sh_src;
    logic [WIDTH-1:0] sh_out;
    logic [WIDTH-1:0] shl_out;
    logic             sh_fill;
    logic [WIDTH-1:0] alu_z;
    logic             alu_c;
    logic             alu_cmp;
    logic [WIDTH-1:0] mul_sum;

    // ---------------- combinational datapath for single-cycle ops ----------------
    assign add_full = {1'b0, X} + {1'b0, Y};
    assign sub_full = {1'b0, X} - {1'b0, Y};
    assign x_lt_y   = sgn ? ($signed(X) < $signed(Y)) : (X < Y);
    assign y_lt_x   = sgn ? ($signed(Y) < $signed(X)) : (Y < X);
    assign x_eq_y   = (X == Y);

    // One right-shift barrel serves SHR, SRA and (via bit reversal) SHL.
    assign shamt   = Y[SHW-1:0];
    assign sh_src  = (code == OP_SHL) ? x_rev : X;
    assign sh_fill = (code == OP_SRA) && X[WIDTH-1];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign x_rev[gi]   = X[WIDTH-1-gi];
            assign shl_out[gi] = sh_out[WIDTH-1-gi];
        end
    endgenerate

    always_comb begin
        sh_out = sh_src;
        for (int i = 0; i < SHW; i++) begin
            if (shamt[i]) begin
                sh_out = (sh_out >> (1 << i))
                       | (sh_fill ? ~({WIDTH{1'b1}} >> (1 << i)) : '0);
            end
        end
    end

    always_comb begin
        alu_z   = '0;
        alu_c   = c_reg;
        alu_cmp = cmp_reg;
        case (code)
            OP_ADD: begin
                alu_z = add_full[WIDTH-1:0];
                alu_c = add_full[WIDTH];
            end
            OP_SUB: begin
                alu_z = sub_full[WIDTH-1:0];
                alu_c = sub_full[WIDTH];
            end
            OP_AND: alu_z = X & Y;
            OP_OR:  alu_z = X | Y;
            OP_XOR: alu_z = X ^ Y;
            OP_NOT: alu_z = ~X;
            OP_MAX: alu_z = x_lt_y ? Y : X;
            OP_MIN: alu_z = y_lt_x ? Y : X;
            OP_LT:  alu_cmp = x_lt_y;
            OP_EQ:  alu_cmp = x_eq_y;
            OP_LE:  alu_cmp = x_lt_y || x_eq_y;
            OP_SHL: alu_z = shl_out;
            OP_SHR: alu_z = sh_out;
            OP_SRA: alu_z = sh_out;
            default: alu_z = '0;
        endcase
    end

    // ---------------- control ----------------
    assign in_ready = (state_reg == IDLE) || ((state_reg == HOLD) && out_ready);
    assign accept   = in_valid && in_ready;
    assign mul_sum  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    always_comb begin
        state_next  = state_reg;
        z_next      = z_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        cnt_next    = cnt_reg;
        cmp_next    = cmp_reg;
        c_next      = c_reg;
        zf_next     = zf_reg;
        case (state_reg)
            IDLE, HOLD: begin
                if (accept) begin
                    if (code == OP_MUL) begin
                        state_next  = MUL;
                        acc_next    = '0;
                        mcand_next  = X;
                        mplier_next = Y;
                        cnt_next    = '0;
                    end else begin
                        state_next = HOLD;
                        z_next     = alu_z;
                        zf_next    = (alu_z == '0);
                        c_next     = alu_c;
                        cmp_next   = alu_cmp;
                    end
                end else if ((state_reg == HOLD) && out_ready) begin
                    state_next = IDLE;
                end
            end
            MUL: begin
                // Multiplier bits are consumed LSB first; the last one lands directly in Z.
                acc_next    = mul_sum;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg + 1'b1;
                if (cnt_reg == SHW'(WIDTH - 1)) begin
                    state_next = HOLD;
                    z_next     = mul_sum;
                    zf_next    = (mul_sum == '0);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            z_reg      <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            cmp_reg    <= 1'b0;
            c_reg      <= 1'b0;
            zf_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            z_reg      <= z_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            cnt_reg    <= cnt_next;
            cmp_reg    <= cmp_next;
            c_reg      <= c_next;
            zf_reg     <= zf_next;
        end
    end

    assign out_valid = (state_reg == HOLD);
    assign Z         = z_reg;
    assign CMP_Flag  = cmp_reg;
    assign C_Flag    = c_reg;
    assign Z_Flag    = zf_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: table of single-cycle vectors plus hand-written
// sequences for multiply latency, backpressure and reset corner cases.
module tb_alu_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  code;
    logic        sgn;
    logic [31:0] X;
    logic [31:0] Y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Z;
    logic        CMP_Flag;
    logic        C_Flag;
    logic        Z_Flag;

    int errors = 0;
    int checks = 0;

    alu_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .code      (code),
        .sgn       (sgn),
        .X         (X),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Z         (Z),
        .CMP_Flag  (CMP_Flag),
        .C_Flag    (C_Flag),
        .Z_Flag    (Z_Flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic [5:0]  code;
        logic        sgn;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic        c;
        logic        cmp;
        logic        zf;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [5:0] c, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] z, input logic cf,
                           input logic cmpf, input logic zf);
        vec_t v;
        v.code = c; v.sgn = s; v.x = a; v.y = b; v.z = z;
        v.c = cf; v.cmp = cmpf; v.zf = zf;
        vq.push_back(v);
    endtask

    task automatic drive(input logic [5:0] c, input logic s, input logic [31:0] a, input logic [31:0] b);
        code = c; sgn = s; X = a; Y = b; in_valid = 1'b1;
    endtask

    initial begin
        vec_t v;
        int   lat;
        logic found;
        logic ready_bad;
        logic spur;

        //       code   sgn  X             Y             Z             C     CMP   ZF
        add_vec(6'd0,  1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1);
        add_vec(6'd1,  1'b0, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
        add_vec(6'd1,  1'b0, 32'h00000007, 32'h00000005, 32'h00000002, 1'b0, 1'b0, 1'b0);
        add_vec(6'd8,  1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b1);
        add_vec(6'd3,  1'b0, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b1, 1'b0);
        add_vec(6'd8,  1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1);
        add_vec(6'd9,  1'b0, 32'h00001234, 32'h00001234, 32'h00000000, 1'b0, 1'b1, 1'b1);
        add_vec(6'd10, 1'b1, 32'h00000005, 32'hFFFFFFFB, 32'h00000000, 1'b0, 1'b0, 1'b1);
        add_vec(6'd10, 1'b0, 32'h00000005, 32'hFFFFFFFB, 32'h00000000, 1'b0, 1'b1, 1'b1);
        add_vec(6'd7,  1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 1'b0);
        add_vec(6'd14, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 1'b0);
        add_vec(6'd7,  1'b0, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
        add_vec(6'd14, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
        add_vec(6'd7,  1'b1, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
        add_vec(6'd4,  1'b0, 32'h000000A0, 32'h0000000A, 32'h000000AA, 1'b0, 1'b1, 1'b0);
        add_vec(6'd5,  1'b0, 32'h000000FF, 32'h0000000F, 32'h000000F0, 1'b0, 1'b1, 1'b0);
        add_vec(6'd6,  1'b0, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
        add_vec(6'd12, 1'b0, 32'h80000010, 32'h00000024, 32'h08000001, 1'b0, 1'b1, 1'b0);
        add_vec(6'd13, 1'b0, 32'h80000010, 32'h00000004, 32'hF8000001, 1'b0, 1'b1, 1'b0);
        add_vec(6'd11, 1'b0, 32'h80000010, 32'h00000001, 32'h00000020, 1'b0, 1'b1, 1'b0);
        add_vec(6'd11, 1'b0, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b1, 1'b0);
        add_vec(6'd13, 1'b0, 32'h7FFFFFFF, 32'h0000001F, 32'h00000000, 1'b0, 1'b1, 1'b1);
        add_vec(6'd15, 1'b0, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b1);
        add_vec(6'd0,  1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1);
        add_vec(6'd8,  1'b0, 32'h00000003, 32'h00000003, 32'h00000000, 1'b1, 1'b0, 1'b1);
        add_vec(6'd10, 1'b1, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h00000000, 1'b1, 1'b1, 1'b1);
        add_vec(6'd1,  1'b0, 32'h00000003, 32'h00000003, 32'h00000000, 1'b0, 1'b1, 1'b1);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        code = '0; sgn = 1'b0; X = '0; Y = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_z", Z, 0);
        chk("rst_c", C_Flag, 0);
        chk("rst_cmp", CMP_Flag, 0);
        chk("rst_zf", Z_Flag, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Back-to-back single-cycle vectors
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            drive(v.code, v.sgn, v.x, v.y);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_z", i), Z, v.z);
            chk($sformatf("v%0d_c", i), C_Flag, v.c);
            chk($sformatf("v%0d_cmp", i), CMP_Flag, v.cmp);
            chk($sformatf("v%0d_zf", i), Z_Flag, v.zf);
            $display("vec %0d code=%0d sgn=%0d X=%h Y=%h -> Z=%h C=%0d CMP=%0d ZF=%0d",
                     i, v.code, v.sgn, v.x, v.y, Z, C_Flag, CMP_Flag, Z_Flag);
        end

        // Multiply: latency WIDTH, in_ready low throughout
        drive(6'd2, 1'b0, 32'h00010003, 32'h00020005);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        found = 1'b0; ready_bad = 1'b0; lat = 0;
        for (int k = 1; k <= 40 && !found; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                found = 1'b1;
                lat = k;
            end else if (in_ready) begin
                ready_bad = 1'b1;
            end
        end
        chk("mul_latency", lat, 32);
        chk("mul_in_ready_low", ready_bad, 0);
        chk("mul_z", Z, 32'h000B000F);
        chk("mul_zf", Z_Flag, 0);
        chk("mul_c_held", C_Flag, 0);
        chk("mul_cmp_held", CMP_Flag, 1);
        $display("mul X=00010003 Y=00020005 -> Z=%h after %0d cycles", Z, lat);

        // Asynchronous reset mid-cycle while a result is held
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_z", Z, 0);
        chk("arst_c", C_Flag, 0);
        chk("arst_cmp", CMP_Flag, 0);
        chk("arst_zf", Z_Flag, 0);
        $display("async reset -> out_valid=%0d Z=%h", out_valid, Z);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Streaming throughput then backpressure
        drive(6'd0, 1'b0, 32'd1, 32'd2);
        @(posedge clk); @(negedge clk);
        chk("str_add_valid", out_valid, 1);
        chk("str_add_z", Z, 32'd3);
        $display("stream ADD -> Z=%h", Z);
        drive(6'd1, 1'b0, 32'd10, 32'd3);
        @(posedge clk); @(negedge clk);
        chk("str_sub_valid", out_valid, 1);
        chk("str_sub_z", Z, 32'd7);
        $display("stream SUB -> Z=%h", Z);
        drive(6'd5, 1'b0, 32'h000000F0, 32'h000000FF);
        @(posedge clk); @(negedge clk);
        chk("str_xor_valid", out_valid, 1);
        chk("str_xor_z", Z, 32'h0000000F);
        $display("stream XOR -> Z=%h", Z);
        drive(6'd0, 1'b0, 32'h00000100, 32'h00000001);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("bp%0d_z", k), Z, 32'h0000000F);
            chk($sformatf("bp%0d_valid", k), out_valid, 1);
            chk($sformatf("bp%0d_in_ready", k), in_ready, 0);
            $display("backpressure cycle %0d Z=%h in_ready=%0d", k, Z, in_ready);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("bp_pop_accept_valid", out_valid, 1);
        chk("bp_pop_accept_z", Z, 32'h00000101);
        $display("release -> Z=%h", Z);
        @(posedge clk); @(negedge clk);
        chk("bp_drain_valid", out_valid, 0);
        chk("bp_drain_in_ready", in_ready, 1);

        // Reset during multiply abandons it
        drive(6'd2, 1'b0, 32'd3, 32'd5);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mrst_idle_in_ready", in_ready, 1);
        spur = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) spur = 1'b1;
        end
        chk("mrst_no_output", spur, 0);
        $display("reset during mul -> no output seen=%0d", spur);
        @(negedge clk);
        drive(6'd0, 1'b0, 32'd2, 32'd3);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("post_add_valid", out_valid, 1);
        chk("post_add_z", Z, 32'd5);
        chk("post_add_c", C_Flag, 0);
        chk("post_add_zf", Z_Flag, 0);
        $display("post-reset ADD -> Z=%h", Z);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the combinational filter-processor ALU.
- Accepts one operation per transfer and registers the result and flags.
- Adds an iterative multi-cycle multiplier, signed/unsigned mode, arithmetic shift, MIN, and carry/zero flags.
- Sits between the decode/register-read stage and writeback; backpressure propagates through a valid/ready pair on each side.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4, power of two).
- SHW, log2(WIDTH), shift-amount bits taken from Y (derived; do not override).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  block can accept an operation this cycle.
- code  input  6  opcode.
- sgn  input  1  1 = signed compare/max/min; ignored by other ops.
- X  input  WIDTH  operand A.
- Y  input  WIDTH  operand B.
- out_valid  output  1  Z/flags hold a result.
- out_ready  input  1  consumer takes result.
- Z  output  WIDTH  result.
- CMP_Flag  output  1  compare result (sticky).
- C_Flag  output  1  carry out (add) / borrow (sub).
- Z_Flag  output  1  Z == 0 for the last result.

Behaviour:
- Reset (async, rst_n=0): state IDLE; Z=0, out_valid=0, CMP_Flag=0, C_Flag=0, Z_Flag=0; in_ready=1 once reset releases. Reset mid-multiply abandons the operation with no output.
- Accept: transfer when in_valid && in_ready at a rising edge. X, Y, code and sgn are captured at that edge; later input changes have no effect.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). In HOLD, a pop and a new accept in the same cycle are allowed, giving one result per cycle for single-cycle ops.
- States:
  - IDLE: no result held.
  - MUL: iterating; in_ready=0, out_valid=0.
  - HOLD: out_valid=1; Z and flags stable until out_ready.
  - Transitions:
    - IDLE/HOLD + accept of a single-cycle op -> HOLD with the new result.
    - IDLE/HOLD + accept of MUL -> MUL.
    - MUL with counter==WIDTH-1 -> HOLD.
    - HOLD + out_ready with no accept -> IDLE.
- Latency: single-cycle ops give out_valid=1 one cycle after the accepting edge. MUL gives out_valid=1 exactly WIDTH cycles after the accepting edge, via shift-add at one partial product per cycle.
- Opcodes (all arithmetic modulo 2^WIDTH):
  - 0 ADD: Z=X+Y, C_Flag = carry out.
  - 1 SUB: Z=X-Y, C_Flag = borrow (X<Y unsigned).
  - 2 MUL: Z = low WIDTH bits of X*Y (identical for signed and unsigned).
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 NOT: bitwise ~X.
  - 7 MAX.
  - 14 MIN: sgn selects the comparison; ties return X.
  - 8 LT, 9 EQ, 10 LE: Z=0, CMP_Flag = result (sgn selects signed for LT/LE).
  - 11 SHL: X<<Y[SHW-1:0].
  - 12 SHR: logical right shift.
  - 13 SRA: arithmetic right shift, always signed.
  - Upper bits of Y are ignored for shifts.
  - Any other code: NOP, Z=0, completes as single-cycle.
- Flags:
  - CMP_Flag is written only by ops 8/9/10 and holds its value otherwise.
  - C_Flag is written only by ops 0/1 and holds otherwise.
  - Z_Flag is updated on every completed op, including compares (Z=0 gives Z_Flag=1).
- Backpressure: while out_ready=0 in HOLD, Z and all flags are frozen and in_ready=0.
- in_valid while in MUL is not accepted. The producer must hold its inputs until in_ready.

Test Plan:
- Reset then ADD 0xFFFFFFFF+0x00000001 -> next cycle: out_valid=1, Z=0, C_Flag=1, Z_Flag=1. Assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately.
- MUL X=0x00010003, Y=0x00020005 -> out_valid rises exactly 32 cycles after accept; Z=0x000B000F (low 32 bits); in_ready=0 throughout MUL.
- Signed/unsigned compare, X=0xFFFFFFFF, Y=1:
  - LT with sgn=1 -> CMP_Flag=1; with sgn=0 -> CMP_Flag=0.
  - A following AND op leaves CMP_Flag unchanged.
  - MAX with sgn=1 -> Z=1; MIN with sgn=0 -> Z=1.
- Shifts X=0x80000010:
  - SHR Y=0x24 (amount 4) -> Z=0x08000001.
  - SRA Y=4 -> Z=0xF8000001.
  - SHL Y=1 -> Z=0x00000020.
- Backpressure/throughput: stream ADD, SUB, XOR with out_ready=1 -> three results on three consecutive cycles. Hold out_ready=0 for 5 cycles -> Z frozen, in_ready=0; release -> pop and accept happen on the same edge.
- Reset during MUL (cycle 10 of 32) -> out_valid stays 0, state IDLE. The next ADD completes normally with the correct result.
